// File: rtl/jtoutrun_pkg.sv
// Shared types and default widths for the Out Run road-ROM responder.
package jtoutrun_pkg;

  localparam int AW_DEF  = 14;
  localparam int SDW_DEF = 22;
  localparam int DW_DEF  = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } fetch_state_t;

  // Round-robin choice: a lone miss wins outright, a tie goes to the pointer.
  function automatic logic rr_pick(input logic i_miss0, input logic i_miss1, input logic i_rr);
    logic v_sel;
    if (i_miss0 && i_miss1) begin
      v_sel = i_rr;
    end else if (i_miss1) begin
      v_sel = 1'b1;
    end else begin
      v_sel = 1'b0;
    end
    return v_sel;
  endfunction

endpackage

// File: rtl/jtoutrun_rdrom_resp_if.sv
// Road-ROM client ports plus the SDRAM slot handshake, bundled for the responder.
interface jtoutrun_rdrom_resp_if #(
  parameter int AW  = jtoutrun_pkg::AW_DEF,
  parameter int SDW = jtoutrun_pkg::SDW_DEF,
  parameter int DW  = jtoutrun_pkg::DW_DEF
);

  logic           rd0_cs;
  logic [AW-1:0]  rd0_addr;
  logic [DW-1:0]  rd0_data;
  logic           rd0_ok;
  logic           rd1_cs;
  logic [AW-1:0]  rd1_addr;
  logic [DW-1:0]  rd1_data;
  logic           rd1_ok;
  logic           sdram_req;
  logic [SDW-1:0] sdram_addr;
  logic           sdram_ack;
  logic           sdram_rdy;
  logic [DW-1:0]  sdram_dout;

  // Environment side: video clients and SDRAM controller.
  modport master (
    output rd0_cs, rd0_addr, rd1_cs, rd1_addr,
    input  rd0_data, rd0_ok, rd1_data, rd1_ok,
    input  sdram_req, sdram_addr,
    output sdram_ack, sdram_rdy, sdram_dout
  );

  // Responder side.
  modport slave (
    input  rd0_cs, rd0_addr, rd1_cs, rd1_addr,
    output rd0_data, rd0_ok, rd1_data, rd1_ok,
    output sdram_req, sdram_addr,
    input  sdram_ack, sdram_rdy, sdram_dout
  );

endinterface

// File: rtl/jtoutrun_rdrom_tag.sv
// One-word tag/data cache for a single road-ROM client.
module jtoutrun_rdrom_tag #(
  parameter int AW = 14,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_cs,
  input  logic [AW-1:0] i_addr,
  input  logic          i_fill,
  input  logic [AW-1:0] i_fill_addr,
  input  logic [DW-1:0] i_fill_data,
  output logic          o_hit,
  output logic          o_ok,
  output logic [DW-1:0] o_data
);

  logic [AW-1:0] r_tag;
  logic          r_vld;
  logic [DW-1:0] r_data;

  // Cache entry: loaded only when the fetch for this client completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tag  <= {AW{1'b0}};
      r_vld  <= 1'b0;
      r_data <= {DW{1'b0}};
    end else if (i_fill) begin
      r_tag  <= i_fill_addr;
      r_vld  <= 1'b1;
      r_data <= i_fill_data;
    end else begin
      r_tag  <= r_tag;
      r_vld  <= r_vld;
      r_data <= r_data;
    end
  end

  // ok is combinational so an address change never shows a stale ok.
  assign o_hit  = r_vld && (r_tag == i_addr);
  assign o_ok   = i_cs && o_hit;
  assign o_data = r_data;

endmodule

// File: rtl/jtoutrun_rdrom_resp.sv
// Road-ROM responder: two cached clients sharing one SDRAM read slot via round-robin.
module jtoutrun_rdrom_resp
  import jtoutrun_pkg::*;
#(
  parameter int             AW   = AW_DEF,
  parameter int             SDW  = SDW_DEF,
  parameter logic [SDW-1:0] BASE = {SDW{1'b0}},
  parameter int             DW   = DW_DEF
) (
  input logic                  clk,
  input logic                  rst_n,
  jtoutrun_rdrom_resp_if.slave io_bus
);

  fetch_state_t   r_state, w_state_nxt;
  logic           r_sel, w_sel_nxt;
  logic           r_rr, w_rr_nxt;
  logic           r_req, w_req_nxt;
  logic [AW-1:0]  r_addr, w_addr_nxt;
  logic [SDW-1:0] r_sdaddr, w_sdaddr_nxt;
  logic           w_done;
  logic           w_fill0, w_fill1;
  logic           w_hit0, w_hit1;
  logic           w_busy0, w_busy1;
  logic           w_miss0, w_miss1;
  logic           w_pick;
  logic [AW-1:0]  w_pick_addr;

  jtoutrun_rdrom_tag #(.AW(AW), .DW(DW)) u_tag0 (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_cs        (io_bus.rd0_cs),
    .i_addr      (io_bus.rd0_addr),
    .i_fill      (w_fill0),
    .i_fill_addr (r_addr),
    .i_fill_data (io_bus.sdram_dout),
    .o_hit       (w_hit0),
    .o_ok        (io_bus.rd0_ok),
    .o_data      (io_bus.rd0_data)
  );

  jtoutrun_rdrom_tag #(.AW(AW), .DW(DW)) u_tag1 (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_cs        (io_bus.rd1_cs),
    .i_addr      (io_bus.rd1_addr),
    .i_fill      (w_fill1),
    .i_fill_addr (r_addr),
    .i_fill_data (io_bus.sdram_dout),
    .o_hit       (w_hit1),
    .o_ok        (io_bus.rd1_ok),
    .o_data      (io_bus.rd1_data)
  );

  // A client whose exact address is already being fetched is not a new miss.
  assign w_busy0     = (r_state != ST_IDLE) && (r_sel == 1'b0) && (r_addr == io_bus.rd0_addr);
  assign w_busy1     = (r_state != ST_IDLE) && (r_sel == 1'b1) && (r_addr == io_bus.rd1_addr);
  assign w_miss0     = io_bus.rd0_cs && !w_hit0 && !w_busy0;
  assign w_miss1     = io_bus.rd1_cs && !w_hit1 && !w_busy1;
  assign w_pick      = rr_pick(w_miss0, w_miss1, r_rr);
  assign w_pick_addr = w_pick ? io_bus.rd1_addr : io_bus.rd0_addr;
  assign w_fill0     = w_done && (r_sel == 1'b0);
  assign w_fill1     = w_done && (r_sel == 1'b1);

  // Fetch FSM next-state and request decode.
  always_comb begin
    w_state_nxt  = r_state;
    w_sel_nxt    = r_sel;
    w_rr_nxt     = r_rr;
    w_req_nxt    = r_req;
    w_addr_nxt   = r_addr;
    w_sdaddr_nxt = r_sdaddr;
    w_done       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_miss0 || w_miss1) begin
          w_sel_nxt    = w_pick;
          w_rr_nxt     = r_rr ^ (w_miss0 && w_miss1);
          w_addr_nxt   = w_pick_addr;
          w_sdaddr_nxt = BASE + {{(SDW-AW){1'b0}}, w_pick_addr};
          w_req_nxt    = 1'b1;
          w_state_nxt  = ST_REQ;
        end else begin
          w_state_nxt  = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (io_bus.sdram_ack) begin
          w_req_nxt = 1'b0;
          // Data may come back alongside the ack.
          if (io_bus.sdram_rdy) begin
            w_done      = 1'b1;
            w_state_nxt = ST_IDLE;
          end else begin
            w_state_nxt = ST_WAIT;
          end
        end else begin
          w_state_nxt = ST_REQ;
        end
      end
      ST_WAIT: begin
        if (io_bus.sdram_rdy) begin
          w_done      = 1'b1;
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_WAIT;
        end
      end
      default: begin
        w_req_nxt   = 1'b0;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Fetch FSM state and registered SDRAM request outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_sel    <= 1'b0;
      r_rr     <= 1'b0;
      r_req    <= 1'b0;
      r_addr   <= {AW{1'b0}};
      r_sdaddr <= {SDW{1'b0}};
    end else begin
      r_state  <= w_state_nxt;
      r_sel    <= w_sel_nxt;
      r_rr     <= w_rr_nxt;
      r_req    <= w_req_nxt;
      r_addr   <= w_addr_nxt;
      r_sdaddr <= w_sdaddr_nxt;
    end
  end

  assign io_bus.sdram_req  = r_req;
  assign io_bus.sdram_addr = r_sdaddr;

endmodule

// File: tb/tb_jtoutrun_rdrom_resp.sv
// Scoreboard bench for the road-ROM responder: expected SDRAM addresses and fill data are queued at stimulus time.
module tb_jtoutrun_rdrom_resp;

  localparam logic [21:0] BASE = 22'h10_0000;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_pass;

  logic [21:0] q_addr[$];
  logic [15:0] q_data[$];

  jtoutrun_rdrom_resp_if #(.AW(14), .SDW(22), .DW(16)) bus ();

  jtoutrun_rdrom_resp #(.AW(14), .SDW(22), .BASE(BASE), .DW(16)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .io_bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req(output bit seen);
    int n;
    n = 0;
    while (bus.sdram_req !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    seen = (bus.sdram_req === 1'b1);
  endtask

  // Zero-wait SDRAM: ack in the req cycle, rdy two cycles later.
  task automatic serve(input logic [15:0] dout, output logic [21:0] addr, output bit seen);
    wait_req(seen);
    addr = bus.sdram_addr;
    if (seen) begin
      bus.sdram_ack = 1'b1;
      tick();
      bus.sdram_ack = 1'b0;
      tick();
      bus.sdram_rdy  = 1'b1;
      bus.sdram_dout = dout;
      tick();
      bus.sdram_rdy  = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.rd0_cs = 1'b1; bus.rd0_addr = 14'h0000;
    bus.rd1_cs = 1'b1; bus.rd1_addr = 14'h0000;
    bus.sdram_ack = 1'b0; bus.sdram_rdy = 1'b0; bus.sdram_dout = 16'h0000;
    repeat (2) tick();
    n_chk++; if (bus.sdram_req !== 1'b0) $display("FAIL reset_req: got %b want 0", bus.sdram_req); else n_pass++;
    n_chk++; if (bus.sdram_addr !== 22'h0) $display("FAIL reset_addr: got %h want 0", bus.sdram_addr); else n_pass++;
    n_chk++; if (bus.rd0_ok !== 1'b0 || bus.rd1_ok !== 1'b0) $display("FAIL reset_ok: got %b%b want 00", bus.rd0_ok, bus.rd1_ok); else n_pass++;
    n_chk++; if (bus.rd0_data !== 16'h0 || bus.rd1_data !== 16'h0) $display("FAIL reset_data: got %h %h want 0 0", bus.rd0_data, bus.rd1_data); else n_pass++;
    bus.rd0_cs = 1'b0;
    bus.rd1_cs = 1'b0;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    logic [21:0] got;
    logic [15:0] d;
    bit seen;
    d = 16'hBEEF; q_addr.push_back(BASE + 22'h0123); q_data.push_back(d);
    bus.rd0_cs = 1'b1; bus.rd0_addr = 14'h0123;
    #1;
    n_chk++; if (bus.rd0_ok !== 1'b0) $display("FAIL miss_ok0: got %b want 0", bus.rd0_ok); else n_pass++;
    tick();
    n_chk++; if (bus.sdram_req !== 1'b1) $display("FAIL req_latency: got %b want 1", bus.sdram_req); else n_pass++;
    serve(d, got, seen);
    n_chk++; if (!seen || got !== q_addr[0]) $display("FAIL basic_addr: got %h want %h", got, q_addr[0]); else n_pass++;
    void'(q_addr.pop_front());
    n_chk++; if (bus.rd0_ok !== 1'b1) $display("FAIL basic_ok: got %b want 1", bus.rd0_ok); else n_pass++;
    n_chk++; if (bus.rd0_data !== q_data[0]) $display("FAIL basic_data: got %h want %h", bus.rd0_data, q_data[0]); else n_pass++;
    void'(q_data.pop_front());
    // address change drops ok combinationally and refetches
    d = 16'h1111; q_addr.push_back(BASE + 22'h0124); q_data.push_back(d);
    bus.rd0_addr = 14'h0124;
    #1;
    n_chk++; if (bus.rd0_ok !== 1'b0) $display("FAIL chg_ok_drop: got %b want 0", bus.rd0_ok); else n_pass++;
    serve(d, got, seen);
    n_chk++; if (!seen || got !== q_addr[0]) $display("FAIL chg_addr: got %h want %h", got, q_addr[0]); else n_pass++;
    void'(q_addr.pop_front());
    n_chk++; if (bus.rd0_ok !== 1'b1 || bus.rd0_data !== q_data[0]) $display("FAIL chg_data: got ok=%b %h want ok=1 %h", bus.rd0_ok, bus.rd0_data, q_data[0]); else n_pass++;
    void'(q_data.pop_front());
    // single entry: old address misses again
    d = 16'h2222; q_addr.push_back(BASE + 22'h0123); q_data.push_back(d);
    bus.rd0_addr = 14'h0123;
    #1;
    n_chk++; if (bus.rd0_ok !== 1'b0) $display("FAIL refetch_miss: got %b want 0", bus.rd0_ok); else n_pass++;
    serve(d, got, seen);
    n_chk++; if (!seen || got !== q_addr[0]) $display("FAIL refetch_addr: got %h want %h", got, q_addr[0]); else n_pass++;
    void'(q_addr.pop_front());
    n_chk++; if (bus.rd0_ok !== 1'b1 || bus.rd0_data !== q_data[0]) $display("FAIL refetch_data: got ok=%b %h want ok=1 %h", bus.rd0_ok, bus.rd0_data, q_data[0]); else n_pass++;
    void'(q_data.pop_front());
  endtask

  task automatic test_round_robin();
    logic [21:0] got;
    bit seen;
    // pointer starts at client 0
    q_addr.push_back(BASE + 22'h0010); q_data.push_back(16'hA010);
    q_addr.push_back(BASE + 22'h0020); q_data.push_back(16'hA020);
    bus.rd0_cs = 1'b1; bus.rd0_addr = 14'h0010;
    bus.rd1_cs = 1'b1; bus.rd1_addr = 14'h0020;
    #1;
    serve(q_data[0], got, seen);
    n_chk++; if (!seen || got !== q_addr[0]) $display("FAIL rr1_first: got %h want %h", got, q_addr[0]); else n_pass++;
    void'(q_addr.pop_front());
    n_chk++; if (bus.rd0_ok !== 1'b1 || bus.rd1_ok !== 1'b0 || bus.rd0_data !== q_data[0]) $display("FAIL rr1_first_ok: got ok=%b%b %h want ok=10 %h", bus.rd0_ok, bus.rd1_ok, bus.rd0_data, q_data[0]); else n_pass++;
    void'(q_data.pop_front());
    serve(q_data[0], got, seen);
    n_chk++; if (!seen || got !== q_addr[0]) $display("FAIL rr1_second: got %h want %h", got, q_addr[0]); else n_pass++;
    void'(q_addr.pop_front());
    n_chk++; if (bus.rd1_ok !== 1'b1 || bus.rd1_data !== q_data[0]) $display("FAIL rr1_second_ok: got ok=%b %h want ok=1 %h", bus.rd1_ok, bus.rd1_data, q_data[0]); else n_pass++;
    void'(q_data.pop_front());
    // pointer toggled: client 1 wins this tie
    q_addr.push_back(BASE + 22'h0040); q_data.push_back(16'hB040);
    q_addr.push_back(BASE + 22'h0030); q_data.push_back(16'hB030);
    bus.rd0_addr = 14'h0030;
    bus.rd1_addr = 14'h0040;
    #1;
    serve(q_data[0], got, seen);
    n_chk++; if (!seen || got !== q_addr[0]) $display("FAIL rr2_first: got %h want %h", got, q_addr[0]); else n_pass++;
    void'(q_addr.pop_front());
    n_chk++; if (bus.rd1_ok !== 1'b1 || bus.rd0_ok !== 1'b0 || bus.rd1_data !== q_data[0]) $display("FAIL rr2_first_ok: got ok=%b%b %h want ok=01 %h", bus.rd0_ok, bus.rd1_ok, bus.rd1_data, q_data[0]); else n_pass++;
    void'(q_data.pop_front());
    serve(q_data[0], got, seen);
    n_chk++; if (!seen || got !== q_addr[0]) $display("FAIL rr2_second: got %h want %h", got, q_addr[0]); else n_pass++;
    void'(q_addr.pop_front());
    n_chk++; if (bus.rd0_ok !== 1'b1 || bus.rd0_data !== q_data[0]) $display("FAIL rr2_second_ok: got ok=%b %h want ok=1 %h", bus.rd0_ok, bus.rd0_data, q_data[0]); else n_pass++;
    void'(q_data.pop_front());
  endtask

  task automatic test_addr_change_wait();
    logic [21:0] got;
    bit seen;
    bus.rd1_cs = 1'b0;
    q_addr.push_back(BASE + 22'h0100);
    bus.rd0_addr = 14'h0100;
    #1;
    wait_req(seen);
    got = bus.sdram_addr;
    n_chk++; if (!seen || got !== q_addr[0]) $display("FAIL wait_addr0: got %h want %h", got, q_addr[0]); else n_pass++;
    void'(q_addr.pop_front());
    bus.sdram_ack = 1'b1;
    tick();
    bus.sdram_ack = 1'b0;
    q_addr.push_back(BASE + 22'h0200);
    bus.rd0_addr = 14'h0200;
    tick();
    bus.sdram_rdy = 1'b1; bus.sdram_dout = 16'hC100;
    tick();
    bus.sdram_rdy = 1'b0;
    n_chk++; if (bus.rd0_ok !== 1'b0) $display("FAIL stale_fill_ok: got %b want 0", bus.rd0_ok); else n_pass++;
    n_chk++; if (bus.rd0_data !== 16'hC100) $display("FAIL stale_fill_data: got %h want c100", bus.rd0_data); else n_pass++;
    q_data.push_back(16'hC200);
    serve(q_data[0], got, seen);
    n_chk++; if (!seen || got !== q_addr[0]) $display("FAIL wait_addr1: got %h want %h", got, q_addr[0]); else n_pass++;
    void'(q_addr.pop_front());
    n_chk++; if (bus.rd0_ok !== 1'b1 || bus.rd0_data !== q_data[0]) $display("FAIL wait_fill2: got ok=%b %h want ok=1 %h", bus.rd0_ok, bus.rd0_data, q_data[0]); else n_pass++;
    void'(q_data.pop_front());
  endtask

  task automatic test_cs_drop();
    logic [21:0] got;
    bit seen;
    bus.rd0_cs = 1'b0;
    q_addr.push_back(BASE + 22'h0555); q_data.push_back(16'hD555);
    bus.rd1_cs = 1'b1; bus.rd1_addr = 14'h0555;
    #1;
    wait_req(seen);
    got = bus.sdram_addr;
    n_chk++; if (!seen || got !== q_addr[0]) $display("FAIL drop_addr: got %h want %h", got, q_addr[0]); else n_pass++;
    void'(q_addr.pop_front());
    bus.sdram_ack = 1'b1;
    tick();
    bus.sdram_ack = 1'b0;
    bus.rd1_cs = 1'b0;
    bus.rd0_cs = 1'b1;
    #1;
    // client 0 still holds 0200 and is served during the fetch
    n_chk++; if (bus.rd0_ok !== 1'b1) $display("FAIL other_hit: got %b want 1", bus.rd0_ok); else n_pass++;
    tick();
    bus.sdram_rdy = 1'b1; bus.sdram_dout = q_data[0];
    tick();
    bus.sdram_rdy = 1'b0;
    bus.rd1_cs = 1'b1;
    #1;
    n_chk++; if (bus.rd1_ok !== 1'b1 || bus.rd1_data !== q_data[0]) $display("FAIL drop_fill: got ok=%b %h want ok=1 %h", bus.rd1_ok, bus.rd1_data, q_data[0]); else n_pass++;
    void'(q_data.pop_front());
    repeat (3) tick();
    n_chk++; if (bus.sdram_req !== 1'b0) $display("FAIL drop_no_req: got %b want 0", bus.sdram_req); else n_pass++;
  endtask

  task automatic test_same_addr();
    logic [21:0] got;
    bit seen;
    q_addr.push_back(BASE + 22'h0777); q_data.push_back(16'hE000);
    q_addr.push_back(BASE + 22'h0777); q_data.push_back(16'hE001);
    bus.rd0_addr = 14'h0777;
    bus.rd1_addr = 14'h0777;
    #1;
    serve(q_data[0], got, seen);
    n_chk++; if (!seen || got !== q_addr[0]) $display("FAIL same_first: got %h want %h", got, q_addr[0]); else n_pass++;
    void'(q_addr.pop_front());
    n_chk++; if (bus.rd0_ok !== 1'b1 || bus.rd1_ok !== 1'b0) $display("FAIL same_no_share: got ok=%b%b want 10", bus.rd0_ok, bus.rd1_ok); else n_pass++;
    void'(q_data.pop_front());
    serve(q_data[0], got, seen);
    n_chk++; if (!seen || got !== q_addr[0]) $display("FAIL same_second: got %h want %h", got, q_addr[0]); else n_pass++;
    void'(q_addr.pop_front());
    n_chk++; if (bus.rd1_ok !== 1'b1 || bus.rd1_data !== q_data[0]) $display("FAIL same_second_ok: got ok=%b %h want ok=1 %h", bus.rd1_ok, bus.rd1_data, q_data[0]); else n_pass++;
    void'(q_data.pop_front());
  endtask

  task automatic test_reset_mid();
    bus.rd0_addr = 14'h0999;
    #1;
    tick();
    n_chk++; if (bus.sdram_req !== 1'b1) $display("FAIL mid_req: got %b want 1", bus.sdram_req); else n_pass++;
    #2;
    rst_n = 1'b0;
    #1;
    n_chk++; if (bus.sdram_req !== 1'b0) $display("FAIL async_req: got %b want 0", bus.sdram_req); else n_pass++;
    n_chk++; if (bus.rd0_ok !== 1'b0 || bus.rd1_ok !== 1'b0) $display("FAIL async_ok: got %b%b want 00", bus.rd0_ok, bus.rd1_ok); else n_pass++;
    tick();
    rst_n = 1'b1;
    bus.sdram_rdy = 1'b1; bus.sdram_dout = 16'hFFFF;
    tick();
    tick();
    bus.sdram_rdy = 1'b0;
    n_chk++; if (bus.rd0_ok !== 1'b0 || bus.rd1_ok !== 1'b0) $display("FAIL late_rdy_ok: got %b%b want 00", bus.rd0_ok, bus.rd1_ok); else n_pass++;
    n_chk++; if (bus.sdram_req !== 1'b1 || bus.sdram_addr !== BASE + 22'h0999) $display("FAIL rel_req: got %b %h want 1 %h", bus.sdram_req, bus.sdram_addr, BASE + 22'h0999); else n_pass++;
  endtask

  initial begin
    n_chk  = 0;
    n_pass = 0;
    test_reset();
    test_basic();
    test_round_robin();
    test_addr_change_wait();
    test_cs_drop();
    test_same_addr();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
